// File: rtl/pixel_frame_buffer_if.sv
// Bus between the edge detector's stream controller (master) and one
// direction-path pixel frame buffer (slave).
interface pixel_frame_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 12
);
  logic              resetBuff;
  logic              enb;
  logic              buffMode;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              outValid;
  logic              complete;
  logic              full;
  logic              overflow;
  logic [ADDR_W:0]   count;

  modport master (
    output resetBuff, enb, buffMode, dataIn,
    input  dataOut, outValid, complete, full, overflow, count
  );

  modport slave (
    input  resetBuff, enb, buffMode, dataIn,
    output dataOut, outValid, complete, full, overflow, count
  );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Two-phase pixel buffer: FILL stores pixels in arrival order, DRAIN replays
// them one per enabled clock, DONE holds the last pixel with complete set.
module pixel_frame_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input logic                clk,
  input logic                reset,
  pixel_frame_buffer_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;
  logic              complete_q, complete_d;
  logic [DATA_W-1:0] data_out_q;

  logic wr_en_c;
  logic rd_en_c;
  logic last_rd_c;

  // The read that consumes entry count-1 is the last one of the frame.
  assign last_rd_c = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.resetBuff) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (bus.enb && bus.buffMode) begin
            state_d = ((count_q == '0) || last_rd_c) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.enb && last_rd_c) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    complete_d  = complete_q;
    if (bus.resetBuff) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
      complete_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (bus.enb && bus.buffMode) begin
            // Mode switch edge doubles as the first read; an empty frame completes at once.
            if (count_q == '0) begin
              complete_d = 1'b1;
            end else begin
              rd_en_c     = 1'b1;
              rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
              out_valid_d = 1'b1;
            end
          end else if (bus.enb) begin
            if (full_q) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_c  = 1'b1;
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
              count_d  = count_q + CNT_W'(1);
              full_d   = (count_q == CNT_W'(DEPTH - 1));
            end
          end
        end
        ST_DRAIN: begin
          if (bus.enb) begin
            rd_en_c     = 1'b1;
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            out_valid_d = 1'b1;
          end
        end
        ST_DONE:  complete_d = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      complete_q  <= complete_d;
    end
  end

  // Single write port; contents survive both resets.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= bus.dataIn;
    end
  end

  // Registered read port, holds its value whenever no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (bus.resetBuff) begin
      data_out_q <= '0;
    end else if (rd_en_c) begin
      data_out_q <= mem[rd_ptr_q];
    end
  end

  assign bus.dataOut  = data_out_q;
  assign bus.outValid = out_valid_q;
  assign bus.complete = complete_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Bench for pixel_frame_buffer: directed frames plus random frames, every
// cycle compared against a queue-based model of the fill/drain protocol.
module tb_pixel_frame_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic clk = 1'b0;
  logic reset;

  pixel_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pixel_frame_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stored pixels in a queue, phase 0=fill 1=drain 2=done.
  logic [DATA_W-1:0] m_q[$];
  int                m_phase;
  int                m_idx;
  logic [DATA_W-1:0] m_out;
  bit                m_valid;
  bit                m_complete;
  bit                m_overflow;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_phase    = 0;
    m_idx      = 0;
    m_out      = '0;
    m_valid    = 1'b0;
    m_complete = 1'b0;
    m_overflow = 1'b0;
  endtask

  task automatic model_step(input bit rb, input bit en, input bit mode, input logic [DATA_W-1:0] din);
    if (rb) begin
      model_clear();
    end else begin
      m_valid = 1'b0;
      case (m_phase)
        0: if (en) begin
          if (!mode) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(din);
            else m_overflow = 1'b1;
          end else if (m_q.size() == 0) begin
            m_phase    = 2;
            m_complete = 1'b1;
          end else begin
            m_out   = m_q[0];
            m_valid = 1'b1;
            m_idx   = 1;
            m_phase = (m_idx == m_q.size()) ? 2 : 1;
          end
        end
        1: if (en) begin
          m_out   = m_q[m_idx];
          m_valid = 1'b1;
          m_idx++;
          if (m_idx == m_q.size()) m_phase = 2;
        end
        default: m_complete = 1'b1;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".dataOut"},  32'(bus.dataOut),  32'(m_out));
    check_eq({tag, ".outValid"}, 32'(bus.outValid), 32'(m_valid));
    check_eq({tag, ".complete"}, 32'(bus.complete), 32'(m_complete));
    check_eq({tag, ".full"},     32'(bus.full),     32'(m_q.size() == int'(DEPTH)));
    check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'(m_overflow));
    check_eq({tag, ".count"},    32'(bus.count),    32'(m_q.size()));
  endtask

  task automatic cycle(input bit rb, input bit en, input bit mode, input logic [DATA_W-1:0] din);
    bus.resetBuff = rb;
    bus.enb       = en;
    bus.buffMode  = mode;
    bus.dataIn    = din;
    @(posedge clk);
    model_step(rb, en, mode, din);
    #1;
    check_all("cyc");
  endtask

  int  fill_len;
  int  total;
  bit  r_rb;
  bit  r_en;
  bit  r_mode;

  initial begin
    reset         = 1'b1;
    bus.resetBuff = 1'b0;
    bus.enb       = 1'b0;
    bus.buffMode  = 1'b0;
    bus.dataIn    = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic frame
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 8'(10 * i));
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 1, 8'd0);
      check_eq("basic.px", 32'(bus.dataOut), 32'(10 * i));
      check_eq("basic.cmp_low", 32'(bus.complete), 32'd0);
    end
    cycle(0, 1, 1, 8'd0);
    check_eq("basic.complete", 32'(bus.complete), 32'd1);
    check_eq("basic.count", 32'(bus.count), 32'd5);
    cycle(1, 0, 0, 8'd0);

    // Pause mid-drain
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 8'(10 * i));
    cycle(0, 1, 1, 8'd0);
    cycle(0, 1, 1, 8'd0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 8'd0);
      check_eq("pause.hold", 32'(bus.dataOut), 32'd20);
      check_eq("pause.valid", 32'(bus.outValid), 32'd0);
    end
    cycle(0, 1, 0, 8'd0);
    check_eq("pause.resume", 32'(bus.dataOut), 32'd30);
    repeat (4) cycle(0, 1, 1, 8'd0);
    cycle(1, 0, 0, 8'd0);

    // Overflow: DEPTH+1 writes
    for (int i = 1; i <= int'(DEPTH) + 1; i++) begin
      cycle(0, 1, 0, 8'(i));
      if (i == int'(DEPTH)) check_eq("ovf.full", 32'(bus.full), 32'd1);
    end
    check_eq("ovf.sticky", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      cycle(0, 1, 1, 8'd0);
      check_eq("ovf.px", 32'(bus.dataOut), 32'(i));
    end
    cycle(0, 1, 1, 8'd0);
    check_eq("ovf.complete", 32'(bus.complete), 32'd1);
    cycle(1, 0, 0, 8'd0);

    // Empty drain
    cycle(0, 1, 1, 8'd0);
    check_eq("empty.complete", 32'(bus.complete), 32'd1);
    check_eq("empty.valid", 32'(bus.outValid), 32'd0);
    cycle(0, 1, 1, 8'd0);
    cycle(1, 0, 0, 8'd0);

    // Mid-drain clear then refill
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 8'(100 + i));
    cycle(0, 1, 1, 8'd0);
    cycle(0, 1, 1, 8'd0);
    cycle(1, 1, 1, 8'd0);
    cycle(0, 1, 0, 8'd7);
    cycle(0, 1, 0, 8'd8);
    check_eq("clr.count", 32'(bus.count), 32'd2);
    cycle(0, 1, 1, 8'd0);
    check_eq("clr.px7", 32'(bus.dataOut), 32'd7);
    cycle(0, 1, 1, 8'd0);
    check_eq("clr.px8", 32'(bus.dataOut), 32'd8);
    cycle(0, 1, 1, 8'd0);
    check_eq("clr.complete", 32'(bus.complete), 32'd1);
    cycle(1, 0, 0, 8'd0);

    // Asynchronous reset during drain
    for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 8'(50 + i));
    cycle(0, 1, 1, 8'd0);
    @(negedge clk);
    bus.enb = 1'b0;
    reset   = 1'b1;
    #1;
    model_clear();
    check_all("async");
    @(posedge clk);
    #1;
    check_all("async_hold");
    @(negedge clk);
    reset = 1'b0;

    // Random frames
    for (int f = 0; f < 60; f++) begin
      fill_len = $urandom_range(0, DEPTH + 2);
      total    = fill_len + int'(DEPTH) + 4;
      for (int c = 0; c < total; c++) begin
        r_rb   = ($urandom_range(0, 59) == 0);
        r_en   = ($urandom_range(0, 3) != 0);
        r_mode = (c >= fill_len) ? 1'b1 : ($urandom_range(0, 19) == 0);
        cycle(r_rb, r_en, r_mode, 8'($urandom));
      end
      cycle(1, 0, 0, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
